// File: rtl/halton_seq_gen_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | halton_pkg                                                                 |
// | Constant-evaluable helpers for sizing the Halton sequence generator.       |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
package halton_pkg;

  function automatic int unsigned clog2(input longint unsigned v);
    int unsigned r;
    r = 0;
    for (int i = 0; i < 64; i++) begin
      if ((64'd1 << i) < v) r = i + 1;
    end
    return r;
  endfunction

  function automatic longint unsigned ipow(input longint unsigned b, input int unsigned e);
    longint unsigned r;
    r = 1;
    for (int unsigned i = 0; i < e; i++) begin
      r = r * b;
    end
    return r;
  endfunction

endpackage
`default_nettype wire

// File: rtl/halton_seq_gen_digit_cnt.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | halton_digit_cnt                                                           |
// | One mod-BASE digit of the cascaded index counter, with sanitising load.    |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module halton_digit_cnt
  import halton_pkg::*;
#(
  parameter  int unsigned BASE    = 3,
  localparam int unsigned LOGBASE = clog2(BASE)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               load,
  input  logic [LOGBASE-1:0] ld_val,
  input  logic               cin,
  output logic               cout,
  output logic [LOGBASE-1:0] digit
);

  localparam logic [LOGBASE-1:0] c_MAX      = LOGBASE'(BASE - 1);
  localparam logic [LOGBASE:0]   c_BASE_EXT = (LOGBASE + 1)'(BASE);

  logic [LOGBASE-1:0] digit_q;
  logic [LOGBASE-1:0] digit_d;

  always_comb begin
    digit_d = digit_q;
    if (load) begin
      // Out-of-range seed digits would break the mod-BASE cycle, so they load as 0.
      digit_d = ({1'b0, ld_val} >= c_BASE_EXT) ? '0 : ld_val;
    end else if (cin) begin
      digit_d = (digit_q == c_MAX) ? '0 : digit_q + 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      digit_q <= '0;
    end else begin
      digit_q <= digit_d;
    end
  end

  assign cout  = cin & (digit_q == c_MAX);
  assign digit = digit_q;

endmodule
`default_nettype wire

// File: rtl/halton_seq_gen.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | halton_seq_gen                                                             |
// | Radical-inverse (Halton) sample generator over a base-BASE digit counter.  |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module halton_seq_gen
  import halton_pkg::*;
#(
  parameter  int unsigned BASE    = 3,
  parameter  int unsigned DIGITS  = 4,
  localparam int unsigned LOGBASE = clog2(BASE),
  localparam int unsigned OUTW    = clog2(ipow(BASE, DIGITS)),
  localparam int unsigned SEEDW   = DIGITS * LOGBASE
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             load,
  input  logic [SEEDW-1:0] seed,
  output logic [OUTW-1:0]  out,
  output logic             out_valid,
  output logic             wrap
);

  logic [LOGBASE-1:0] w_digit [DIGITS];
  logic [OUTW-1:0]    w_term  [DIGITS];
  logic [DIGITS:0]    w_carry;
  logic [OUTW-1:0]    w_sum;
  logic               w_accept;

  logic [OUTW-1:0]    out_q,       out_d;
  logic               out_valid_q, out_valid_d;
  logic               wrap_q,      wrap_d;

  assign w_accept   = en & ~load;
  assign w_carry[0] = w_accept;

  generate
    for (genvar i = 0; i < DIGITS; i++) begin : g_digit
      // Digit i lands at weight BASE^(DIGITS-1-i): the digit-reversed index.
      localparam logic [OUTW-1:0] c_WEIGHT = OUTW'(ipow(BASE, DIGITS - 1 - i));

      halton_digit_cnt #(
        .BASE (BASE)
      ) u_digit (
        .clk    (clk),
        .rst    (rst),
        .load   (load),
        .ld_val (seed[i*LOGBASE +: LOGBASE]),
        .cin    (w_carry[i]),
        .cout   (w_carry[i+1]),
        .digit  (w_digit[i])
      );

      assign w_term[i] = OUTW'(w_digit[i]) * c_WEIGHT;
    end
  endgenerate

  always_comb begin
    w_sum = '0;
    for (int k = 0; k < DIGITS; k++) begin
      w_sum = w_sum + w_term[k];
    end
  end

  // Carry out of the top digit is exactly "last index of the period, accepted".
  always_comb begin
    out_d       = out_q;
    out_valid_d = w_accept;
    wrap_d      = 1'b0;
    if (w_accept) begin
      out_d  = w_sum;
      wrap_d = w_carry[DIGITS];
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_q       <= '0;
      out_valid_q <= 1'b0;
      wrap_q      <= 1'b0;
    end else begin
      out_q       <= out_d;
      out_valid_q <= out_valid_d;
      wrap_q      <= wrap_d;
    end
  end

  assign out       = out_q;
  assign out_valid = out_valid_q;
  assign wrap      = wrap_q;

endmodule
`default_nettype wire

// File: tb/tb_halton_seq_gen.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | tb_halton_seq_gen                                                          |
// | Bench for two generator instances (base 3 x 2 digits, base 2 x 4 digits).  |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module tb_halton_seq_gen;

  logic       clk = 1'b0;
  logic       rst;
  logic       a_en, a_load, b_en, b_load;
  logic [3:0] a_seed, b_seed;
  logic [3:0] a_out, b_out;
  logic       a_valid, a_wrap, b_valid, b_wrap;

  int n_cmp  = 0;
  int n_fail = 0;

  int a_idx, a_mout, a_mval, a_mwrap;
  int b_idx, b_mout, b_mval, b_mwrap;

  always #5 clk = ~clk;

  halton_seq_gen #(.BASE(3), .DIGITS(2)) u_a (
    .clk(clk), .rst(rst), .en(a_en), .load(a_load), .seed(a_seed),
    .out(a_out), .out_valid(a_valid), .wrap(a_wrap)
  );

  halton_seq_gen #(.BASE(2), .DIGITS(4)) u_b (
    .clk(clk), .rst(rst), .en(b_en), .load(b_load), .seed(b_seed),
    .out(b_out), .out_valid(b_valid), .wrap(b_wrap)
  );

  function automatic int radinv(input int idx, input int base, input int digits);
    int r = 0;
    int x = idx;
    for (int i = 0; i < digits; i++) begin
      r = r * base + x % base;
      x = x / base;
    end
    return r;
  endfunction

  function automatic int seed_to_idx(input logic [3:0] s, input int base, input int logb,
                                     input int digits);
    int idx = 0;
    int w   = 1;
    for (int i = 0; i < digits; i++) begin
      int d = (int'(s) >> (i * logb)) & ((1 << logb) - 1);
      if (d >= base) d = 0;
      idx = idx + d * w;
      w   = w * base;
    end
    return idx;
  endfunction

  task automatic model_upd(input int base, input int digits, input int logb,
                           input logic r, input logic e, input logic l, input logic [3:0] s,
                           inout int idx, inout int mout, inout int mval, inout int mwrap);
    int period = 1;
    for (int i = 0; i < digits; i++) period = period * base;
    if (r) begin
      idx = 0; mout = 0; mval = 0; mwrap = 0;
    end else if (l) begin
      idx = seed_to_idx(s, base, logb, digits); mval = 0; mwrap = 0;
    end else if (e) begin
      mout  = radinv(idx, base, digits);
      mwrap = (idx == period - 1) ? 1 : 0;
      mval  = 1;
      idx   = (idx + 1) % period;
    end else begin
      mval = 0; mwrap = 0;
    end
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic check_all(input string tag);
    check({tag, " A.out"},   32'(a_out),   32'(a_mout));
    check({tag, " A.valid"}, 32'(a_valid), 32'(a_mval));
    check({tag, " A.wrap"},  32'(a_wrap),  32'(a_mwrap));
    check({tag, " B.out"},   32'(b_out),   32'(b_mout));
    check({tag, " B.valid"}, 32'(b_valid), 32'(b_mval));
    check({tag, " B.wrap"},  32'(b_wrap),  32'(b_mwrap));
  endtask

  task automatic step(input string tag, input logic ae, input logic al, input logic [3:0] as,
                      input logic be, input logic bl, input logic [3:0] bs);
    a_en = ae; a_load = al; a_seed = as;
    b_en = be; b_load = bl; b_seed = bs;
    @(posedge clk);
    #1;
    model_upd(3, 2, 2, rst, ae, al, as, a_idx, a_mout, a_mval, a_mwrap);
    model_upd(2, 4, 1, rst, be, bl, bs, b_idx, b_mout, b_mval, b_mwrap);
    check_all(tag);
  endtask

  initial begin
    rst = 1'b1;
    a_en = 0; a_load = 0; a_seed = 0;
    b_en = 0; b_load = 0; b_seed = 0;
    a_idx = 0; a_mout = 0; a_mval = 0; a_mwrap = 0;
    b_idx = 0; b_mout = 0; b_mval = 0; b_mwrap = 0;

    #2;
    check_all("reset");
    step("reset_edge", 1, 0, 4'h0, 1, 0, 4'h0);
    rst = 1'b0;

    // Two full base-3 periods and a full base-2 period with en held high
    for (int i = 0; i < 18; i++) step("run", 1, 0, 4'h0, 1, 0, 4'h0);

    // Seed index 7 (d1=2, d0=1): samples 5, 8 (wrap), 0
    step("load7", 0, 1, 4'b1001, 0, 0, 4'h0);
    for (int i = 0; i < 3; i++) step("from7", 1, 0, 4'h0, 0, 0, 4'h0);

    // Load beats en in the same cycle
    step("load_en", 1, 1, 4'b0110, 1, 1, 4'b1010);
    step("after_load_en", 1, 0, 4'h0, 1, 0, 4'h0);

    // Idle holds state
    step("idle", 0, 0, 4'h0, 0, 0, 4'h0);
    step("idle", 0, 0, 4'h0, 0, 0, 4'h0);
    step("after_idle", 1, 0, 4'h0, 1, 0, 4'h0);

    // Illegal digit value 3 loads as 0: (d1=1, d0=3) -> index 3
    step("load_bad", 0, 1, 4'b0111, 0, 0, 4'h0);
    step("after_bad", 1, 0, 4'h0, 0, 0, 4'h0);

    // Reach index 4, then reset mid-cycle between en cycles
    step("load3", 0, 1, 4'b0100, 0, 0, 4'h0);
    step("en_at3", 1, 0, 4'h0, 1, 0, 4'h0);
    #2;
    rst = 1'b1;
    #1;
    a_idx = 0; a_mout = 0; a_mval = 0; a_mwrap = 0;
    b_idx = 0; b_mout = 0; b_mval = 0; b_mwrap = 0;
    check_all("async_rst");
    step("rst_hold", 1, 0, 4'h0, 1, 0, 4'h0);
    rst = 1'b0;
    step("post_rst", 1, 0, 4'h0, 1, 0, 4'h0);

    // Randomised traffic on both instances
    for (int i = 0; i < 300; i++) begin
      logic ae, al, be, bl;
      logic [3:0] as, bs;
      ae = ($urandom_range(0, 9) < 7);
      al = ($urandom_range(0, 9) == 0);
      be = ($urandom_range(0, 9) < 7);
      bl = ($urandom_range(0, 9) == 0);
      as = 4'($urandom);
      bs = 4'($urandom);
      step("rand", ae, al, as, be, bl, bs);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/halton_seq_gen.md
HALTON_SEQ_GEN -- requirements
Module: halton_seq_gen

Interface
REQ-001 Parameter BASE, default 3, digit radix; legal range 2..16.
REQ-002 Parameter DIGITS, default 4, number of cascaded base-BASE digits; legal range 1..8.
REQ-003 Derived constants: LOGBASE = clog2(BASE); OUTW = clog2(BASE^DIGITS); SEEDW = DIGITS*LOGBASE.
REQ-004 Reset is rst (asynchronous, active-high); clock is clk.
REQ-005 clk  input  1  rising-edge clock.
REQ-006 rst  input  1  asynchronous active-high reset.
REQ-007 en  input  1  advance the index by one and emit one sample.
REQ-008 load  input  1  load the index counter from seed.
REQ-009 seed  input  SEEDW  packed start index; digit i occupies bits [i*LOGBASE +: LOGBASE]; digit 0 is least significant.
REQ-010 out  output  OUTW  radical-inverse sample, an integer numerator over BASE^DIGITS.
REQ-011 out_valid  output  1  out holds a new sample this cycle.
REQ-012 wrap  output  1  the emitted sample is the last of a period (index BASE^DIGITS-1).

Function
REQ-013 The index counter is DIGITS cascaded mod-BASE digits; digit 0 receives carry-in = en; digit i+1 receives carry-in = carry-out of digit i.
REQ-014 Carry-out of a digit = (digit == BASE-1) & carry-in; on carry-out the digit becomes 0, otherwise digit <= digit + carry-in.
REQ-015 Radical inverse: out = sum over i of d_i * BASE^(DIGITS-1-i), using constant weights only; no runtime multipliers or dividers.
REQ-016 Latency 1: on an edge with en=1 and load=0, out and wrap register the radical inverse and wrap status of the pre-increment index; the index advances at the same edge.
REQ-017 out_valid is 1 exactly in the cycle after each accepted en; otherwise 0. out holds its last value while out_valid=0.
REQ-018 wrap = out_valid & (emitted index == BASE^DIGITS-1); at the same edge the counter rolls over to all-zero.
REQ-019 load has priority over en: the counter takes seed, no sample is emitted, and out_valid is 0 in the next cycle.
REQ-020 A seed digit >= BASE is loaded as 0; all other digits load unchanged.
REQ-021 With en held high, output is continuous: one sample per cycle, period BASE^DIGITS, with no bubble at wrap.
REQ-022 With en=0 and load=0, counter state is held.

Reset
REQ-023 While rst=1 the index counter, out, out_valid and wrap are all 0, regardless of clk, en and load.
REQ-024 Reset asserted mid-sequence discards the in-flight sample; the first en after release emits out=0 (index 0).

Structure
REQ-025 Package halton_pkg provides functions clog2 and ipow, both usable in constant expressions, used to derive LOGBASE, OUTW and the digit weights.
REQ-026 One sub-module, halton_digit_cnt, is parameterised by BASE: ports clk, rst, load, ld_val, cin, cout, digit. The top instantiates DIGITS copies in a carry chain.
REQ-027 The weighted sum is combinational from digit registers into the output register; no other pipeline stages.

Verification
REQ-028 BASE=3, DIGITS=2, reset then en held high for 9 cycles -> out = 0,3,6,1,4,7,2,5,8; wrap only with 8; tenth sample = 0.
REQ-029 BASE=3, DIGITS=2, load seed digits {d1=2,d0=1} (index 7) then en -> out = 5, then 8 with wrap=1, then 0.
REQ-030 load=1 and en=1 in the same cycle -> out_valid=0 next cycle; the counter equals seed, not seed+1.
REQ-031 BASE=3, seed digit value 3 -> that digit is loaded as 0; the first sample reflects the zeroed digit.
REQ-032 rst pulsed between two en cycles at index 4 -> out_valid=0 and out=0 during reset; the first post-reset sample is 0.
REQ-033 BASE=2, DIGITS=4, en held 16 cycles -> bit-reversed sequence 0,8,4,12,2,10,6,14,1,9,5,13,3,11,7,15; wrap only on 15.
